// File: rtl/ssio_sdr_tx_ser_pkg.sv
// Shared constants, state encoding and parameter helpers for the SDR transmit serializer.
// Each byte is emitted as a fixed number of lane-wide beats.
package ssio_sdr_tx_ser_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR  = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  function automatic bit lane_width_ok(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction

  function automatic int beats_per_byte(input int w);
    return 8 / w;
  endfunction

  // Byte idx of the frame header: preamble bytes first, SFD at idx == len.
  function automatic logic [7:0] preamble_byte(input int idx, input int len);
    return (idx < len) ? PREAMBLE_BYTE : SFD_BYTE;
  endfunction

endpackage

// File: rtl/ssio_sdr_lane_shifter.sv
// Byte-to-lane shifter: loads a byte, then presents it LSB lane first, one lane per shift.
// last_beat marks the final lane of the byte; penult_beat the one before it.
module ssio_sdr_lane_shifter
  import ssio_sdr_tx_ser_pkg::*;
#(
  parameter int LANE_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [7:0]            load_byte,
  input  logic                  shift,
  input  logic                  clear,
  output logic [LANE_WIDTH-1:0] lane,
  output logic                  last_beat,
  output logic                  penult_beat
);

  localparam int BEATS = beats_per_byte(LANE_WIDTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [7:0]    sr_q;
  logic [BW-1:0] beat_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr_q   <= '0;
      beat_q <= '0;
    end else if (load) begin
      sr_q   <= load_byte;
      beat_q <= '0;
    end else if (shift) begin
      sr_q   <= sr_q >> LANE_WIDTH;
      beat_q <= beat_q + BW'(1);
    end
  end

  assign lane        = sr_q[LANE_WIDTH-1:0];
  assign last_beat   = (beat_q == BW'(BEATS - 1));
  assign penult_beat = (BEATS > 1) && (beat_q == BW'(BEATS - 2));

endmodule

// File: rtl/ssio_sdr_tx_ser.sv
// SDR transmit serializer: frames AXI-stream bytes with preamble/SFD, shifts them out
// LANE_WIDTH bits per clock, aborts on underflow and enforces an inter-frame gap.
module ssio_sdr_tx_ser
  import ssio_sdr_tx_ser_pkg::*;
#(
  parameter int LANE_WIDTH   = 2,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [LANE_WIDTH-1:0] output_d,
  output logic                  output_ctl,
  output logic                  output_err,
  output logic                  status_underflow,
  output logic [2:0]            dbg_state
);

  localparam int   BEATS    = beats_per_byte(LANE_WIDTH);
  localparam int   PW       = ($clog2(PREAMBLE_LEN + 1) > 0) ? $clog2(PREAMBLE_LEN + 1) : 1;
  localparam int   GW       = ($clog2(IFG_CYCLES + 1) > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic ONE_BEAT = (BEATS == 1);

  if (!lane_width_ok(LANE_WIDTH) || IFG_CYCLES < 1) begin : g_bad_param
    $error("ssio_sdr_tx_ser: LANE_WIDTH must be 1/2/4/8 and IFG_CYCLES >= 1");
  end

  logic [2:0]    state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          last_q, last_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          ctl_q, ctl_d, err_q, err_d, tready_q, tready_d, uf_q, uf_d;

  logic          sh_load, sh_shift, sh_clear;
  logic [7:0]    sh_byte;
  logic          last_beat, penult_beat;
  logic          hs;

  // Handshake: a byte transfers on a clock edge where tvalid and tready are both high.
  assign hs = s_axis_tvalid && tready_q;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    last_d    = last_q;
    pre_cnt_d = pre_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ctl_d     = ctl_q;
    err_d     = 1'b0;
    tready_d  = 1'b0;
    uf_d      = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_clear  = 1'b0;
    sh_byte   = hold_q;
    case (state_q)
      ST_IDLE: begin
        tready_d = 1'b1;
        ctl_d    = 1'b0;
        if (hs) begin
          hold_d    = s_axis_tdata;
          last_d    = s_axis_tlast;
          pre_cnt_d = '0;
          sh_load   = 1'b1;
          sh_byte   = preamble_byte(0, PREAMBLE_LEN);
          ctl_d     = 1'b1;
          tready_d  = 1'b0;
          state_d   = ST_PRE;
        end
      end
      ST_PRE: begin
        if (!last_beat) begin
          sh_shift = 1'b1;
        end else if (pre_cnt_q == PW'(PREAMBLE_LEN)) begin
          sh_load  = 1'b1;
          sh_byte  = hold_q;
          tready_d = ONE_BEAT && !last_q;
          state_d  = ST_DATA;
        end else begin
          sh_load   = 1'b1;
          sh_byte   = preamble_byte(int'(pre_cnt_q) + 1, PREAMBLE_LEN);
          pre_cnt_d = pre_cnt_q + PW'(1);
        end
      end
      ST_DATA: begin
        // tready is registered, so it is raised one edge early: as the last beat is loaded.
        if (!last_beat) begin
          sh_shift = 1'b1;
          tready_d = penult_beat && !last_q;
        end else if (last_q) begin
          sh_clear  = 1'b1;
          ctl_d     = 1'b0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (hs) begin
          sh_load  = 1'b1;
          sh_byte  = s_axis_tdata;
          last_d   = s_axis_tlast;
          tready_d = ONE_BEAT && !s_axis_tlast;
        end else begin
          sh_load = 1'b1;
          sh_byte = 8'h00;
          err_d   = 1'b1;
          uf_d    = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        if (!last_beat) begin
          sh_shift = 1'b1;
          err_d    = 1'b1;
        end else begin
          sh_clear  = 1'b1;
          ctl_d     = 1'b0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        ctl_d = 1'b0;
        if (gap_cnt_q == GW'(IFG_CYCLES - 1)) begin
          tready_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        sh_clear = 1'b1;
        ctl_d    = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      last_q    <= 1'b0;
      pre_cnt_q <= '0;
      gap_cnt_q <= '0;
      ctl_q     <= 1'b0;
      err_q     <= 1'b0;
      tready_q  <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      pre_cnt_q <= pre_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      ctl_q     <= ctl_d;
      err_q     <= err_d;
      tready_q  <= tready_d;
      uf_q      <= uf_d;
    end
  end

  ssio_sdr_lane_shifter #(.LANE_WIDTH(LANE_WIDTH)) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load        (sh_load),
    .load_byte   (sh_byte),
    .shift       (sh_shift),
    .clear       (sh_clear),
    .lane        (output_d),
    .last_beat   (last_beat),
    .penult_beat (penult_beat)
  );

  assign output_ctl       = ctl_q;
  assign output_err       = err_q;
  assign s_axis_tready    = tready_q;
  assign status_underflow = uf_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ssio_sdr_tx_ser.sv
// Bench for ssio_sdr_tx_ser: three instances (2-bit, 4-bit, 8-bit lanes) share one scoreboard;
// sel picks the instance being driven and monitored.
module tb_ssio_sdr_tx_ser;

  function automatic int cfg_lw(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_pl(input int i);
    return (i == 2) ? 1 : 7;
  endfunction

  function automatic int cfg_ifg(input int i);
    return (i == 2) ? 1 : 24;
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata_w  [3];
  logic       tvalid_w [3];
  logic       tlast_w  [3];
  logic       tready_w [3];
  logic       ctl_w    [3];
  logic       err_w    [3];
  logic       uf_w     [3];
  logic [7:0] d_w      [3];
  logic [2:0] st_w     [3];

  int sel = 0;
  int checks = 0;
  int passes = 0;

  // Expected byte stream: {kind, byte}; kind 0 = normal byte, 1 = error byte (err on every beat).
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LW = cfg_lw(g);
    logic [LW-1:0] d_l;
    ssio_sdr_tx_ser #(
      .LANE_WIDTH   (LW),
      .PREAMBLE_LEN (cfg_pl(g)),
      .IFG_CYCLES   (cfg_ifg(g))
    ) dut (
      .clk              (clk),
      .rst              (rst),
      .s_axis_tdata     (tdata_w[g]),
      .s_axis_tvalid    (tvalid_w[g]),
      .s_axis_tready    (tready_w[g]),
      .s_axis_tlast     (tlast_w[g]),
      .output_d         (d_l),
      .output_ctl       (ctl_w[g]),
      .output_err       (err_w[g]),
      .status_underflow (uf_w[g]),
      .dbg_state        (st_w[g])
    );
    assign d_w[g] = 8'(d_l);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (sel=%0d, t=%0t)", name, got, exp, sel, $time);
  endtask

  // Monitor: assembles lane beats into bytes while ctl is high and pops the scoreboard.
  logic [7:0] asm_b;
  int asm_n, asm_err, low_run, gap_len, rdy_ctl_cnt, uf_cnt;

  initial begin
    asm_b = '0; asm_n = 0; asm_err = 0; low_run = 0; gap_len = 0;
    rdy_ctl_cnt = 0; uf_cnt = 0;
  end

  always @(negedge clk) begin : monitor
    logic [1:0] kind;
    logic [9:0] e;
    if (rst) begin
      asm_b = '0; asm_n = 0; asm_err = 0; low_run = 0;
    end else begin
      if (uf_w[sel]) uf_cnt++;
      if (ctl_w[sel] && tready_w[sel]) rdy_ctl_cnt++;
      if (ctl_w[sel]) begin
        if (low_run > 0) gap_len = low_run;
        low_run = 0;
        asm_b = asm_b | (d_w[sel] << (asm_n * cfg_lw(sel)));
        if (err_w[sel]) asm_err++;
        asm_n++;
        if (asm_n == 8 / cfg_lw(sel)) begin
          kind = (asm_err == 0) ? 2'd0 : ((asm_err == asm_n) ? 2'd1 : 2'd2);
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_byte: got %0h with empty expected queue (sel=%0d)", {kind, asm_b}, sel);
          end else begin
            e = exp_q.pop_front();
            check("lane_byte", 32'({kind, asm_b}), 32'(e));
          end
          asm_b = '0; asm_n = 0; asm_err = 0;
        end
      end else begin
        low_run++;
        if (asm_n != 0) begin
          checks++;
          $display("FAIL partial_byte: got %0d beats expected %0d (sel=%0d)", asm_n, 8 / cfg_lw(sel), sel);
          asm_b = '0; asm_n = 0; asm_err = 0;
        end
      end
    end
  end

  task automatic push_preamble();
    for (int i = 0; i < cfg_pl(sel); i++) exp_q.push_back({2'b00, 8'h55});
    exp_q.push_back({2'b00, 8'hD5});
  endtask

  // Presents a byte at a negedge and holds it until the handshake edge has passed.
  task automatic send_byte(input logic [7:0] b, input logic last, input bit first);
    int t;
    t = 0;
    @(negedge clk);
    tdata_w[sel] = b; tlast_w[sel] = last; tvalid_w[sel] = 1'b1;
    while (!tready_w[sel] && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      $display("FAIL handshake_timeout: got no tready within %0d cycles for byte %0h", t, b);
      tvalid_w[sel] = 1'b0;
      return;
    end
    if (first) push_preamble();
    exp_q.push_back({2'b00, b});
    @(posedge clk);
    if (first) begin
      @(negedge clk);
      check("ctl_rise_after_hs", 32'(ctl_w[sel]), 32'd1);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    tvalid_w[sel] = 1'b0;
  endtask

  task automatic wait_ctl_low();
    int t;
    t = 0;
    while (ctl_w[sel] && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) begin
      checks++;
      $display("FAIL ctl_low_timeout: got ctl stuck high for %0d cycles", t);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(tready_w[sel] && !ctl_w[sel]) && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) begin
      checks++;
      $display("FAIL idle_timeout: got no idle within %0d cycles", t);
    end
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tvalid_w[i] = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'({ctl_w[sel], err_w[sel], tready_w[sel], uf_w[sel], d_w[sel]}), 32'd0);
    check("reset_state", 32'(st_w[sel]), 32'd0);
    repeat (cyc - 1) @(negedge clk);
    rst = 1'b0;
    check("tready_low_first_cycle", 32'(tready_w[sel]), 32'd0);
    @(negedge clk);
    check("tready_high_idle", 32'(tready_w[sel]), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: got no finish by %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin : stimulus
    logic [1:0] a3_beats [4];
    int n;
    a3_beats = '{2'b11, 2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 3; i++) begin
      tdata_w[i] = '0; tvalid_w[i] = 1'b0; tlast_w[i] = 1'b0;
    end

    // 2-bit lanes: single byte 0xA3, exact SFD/payload beats and gap length.
    sel = 0;
    do_reset(3);
    rdy_ctl_cnt = 0;
    send_byte(8'hA3, 1'b1, 1'b1);
    drop();
    repeat (30) @(negedge clk);
    check("sfd_last_beat", 32'(d_w[sel]), 32'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("a3_beat", 32'(d_w[sel]), 32'(a3_beats[i]));
    end
    wait_ctl_low();
    n = 0;
    while (!tready_w[sel] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("tready_return_after_gap", 32'(n), 32'(cfg_ifg(sel)));
    check("no_tready_single_byte", 32'(rdy_ctl_cnt), 32'd0);

    // Underflow: byte 1 sent, tvalid dropped; remaining bytes become a new frame.
    n = uf_cnt;
    send_byte(8'hE1, 1'b0, 1'b1);
    drop();
    exp_q.push_back({2'b01, 8'h00});
    wait_ctl_low();
    send_byte(8'h2B, 1'b0, 1'b1);
    @(negedge clk);
    check("gap_after_err", 32'(gap_len), 32'(cfg_ifg(sel) + 1));
    send_byte(8'h4D, 1'b1, 1'b0);
    drop();
    check("underflow_pulse_once", 32'(uf_cnt - n), 32'd1);

    // Back-to-back frames with tvalid held throughout.
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h80, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    check("b2b_gap_len", 32'(gap_len), 32'(cfg_ifg(sel) + 1));
    drop();
    wait_idle();

    // Reset while DATA beat 2 is on the lane; the frame is dropped.
    send_byte(8'h5A, 1'b0, 1'b1);
    drop();
    repeat (32) @(negedge clk);
    exp_q.delete();
    do_reset(2);
    send_byte(8'h96, 1'b1, 1'b1);
    drop();
    wait_idle();

    // 4-bit lanes: two bytes, tready high exactly once while the frame is active.
    sel = 1;
    @(negedge clk);
    rdy_ctl_cnt = 0;
    send_byte(8'h12, 1'b0, 1'b1);
    send_byte(8'h34, 1'b1, 1'b0);
    drop();
    wait_ctl_low();
    check("tready_once_in_data", 32'(rdy_ctl_cnt), 32'd1);
    wait_idle();

    // 8-bit lanes, short preamble, minimum gap.
    sel = 2;
    @(negedge clk);
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h0F, 1'b1, 1'b0);
    send_byte(8'h77, 1'b1, 1'b1);
    @(negedge clk);
    check("min_gap_len", 32'(gap_len), 32'(cfg_ifg(sel) + 1));
    drop();
    wait_idle();

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("underflow_total", 32'(uf_cnt), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
